// File: rtl/ts_pkg.sv
// Shared transport-stream constants and sync-lock state encoding.
// Imported by the sync-lock front end and the ts2asi-side blocks.
package ts_pkg;

  localparam logic [7:0] TS_SYNC_BYTE   = 8'h47;
  localparam int         TS_PACKET_SIZE = 188;

  localparam logic [1:0] ST_HUNT   = 2'd0;
  localparam logic [1:0] ST_VERIFY = 2'd1;
  localparam logic [1:0] ST_LOCKED = 2'd2;

endpackage

// File: rtl/ts_sync_lock.sv
// TS packet sync acquisition: hunts for 0x47, verifies a packet
// period later, then forwards locked bytes one cycle after input.
module ts_sync_lock
  import ts_pkg::*;
#(
  parameter int DATA_WIDTH   = 8,
  parameter int PACKET_SIZE  = TS_PACKET_SIZE,
  parameter int LOCK_COUNT   = 3,
  parameter int UNLOCK_COUNT = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  valid,
  input  logic [DATA_WIDTH-1:0] din_8b,
  output logic                  ts_valid,
  output logic                  ts_sync,
  output logic [DATA_WIDTH-1:0] ts_data,
  output logic                  locked,
  output logic                  lock_lost,
  output logic [15:0]           sync_err_cnt
);

  localparam int PW = (PACKET_SIZE > 1) ? $clog2(PACKET_SIZE) : 1;
  localparam int GW = $clog2(LOCK_COUNT + 1);
  localparam int MW = $clog2(UNLOCK_COUNT + 1);

  localparam logic [PW-1:0] POS_LAST = PW'(PACKET_SIZE - 1);
  localparam logic [GW-1:0] GOOD_MAX = GW'(LOCK_COUNT);
  localparam logic [MW-1:0] MISS_MAX = MW'(UNLOCK_COUNT);
  localparam logic [DATA_WIDTH-1:0] SYNC = DATA_WIDTH'(TS_SYNC_BYTE);

  logic [1:0]    state, state_n;
  logic [PW-1:0] pos, pos_n, pos_inc;
  logic [GW-1:0] good, good_n, good_inc;
  logic [MW-1:0] miss, miss_n, miss_inc;
  logic          at_sync, is_sync;
  logic          err_inc, lost_n, fwd;

  // Next-state decision for the byte presented this cycle.
  always_comb begin
    pos_inc  = (pos == POS_LAST) ? '0 : pos + 1'b1;
    good_inc = good + 1'b1;
    miss_inc = miss + 1'b1;
    at_sync  = (pos == '0);
    is_sync  = (din_8b == SYNC);
    state_n  = state;
    pos_n    = pos;
    good_n   = good;
    miss_n   = miss;
    err_inc  = 1'b0;
    lost_n   = 1'b0;
    if (valid) begin
      unique case (state)
        ST_HUNT: begin
          if (is_sync) begin
            pos_n  = pos_inc;
            good_n = GW'(1);
            if (LOCK_COUNT == 1) begin
              state_n = ST_LOCKED;
              miss_n  = '0;
            end else begin
              state_n = ST_VERIFY;
            end
          end
        end
        ST_VERIFY: begin
          if (at_sync && !is_sync) begin
            state_n = ST_HUNT;
            pos_n   = '0;
            good_n  = '0;
          end else begin
            pos_n = pos_inc;
            if (at_sync) begin
              good_n = good_inc;
              if (good_inc == GOOD_MAX) begin
                state_n = ST_LOCKED;
                miss_n  = '0;
              end
            end
          end
        end
        ST_LOCKED: begin
          pos_n = pos_inc;
          if (at_sync) begin
            if (is_sync) begin
              miss_n = '0;
            end else begin
              miss_n  = miss_inc;
              err_inc = 1'b1;
              if (miss_inc == MISS_MAX) begin
                state_n = ST_HUNT;
                pos_n   = '0;
                good_n  = '0;
                lost_n  = 1'b1;
              end
            end
          end
        end
        default: begin
          state_n = ST_HUNT;
          pos_n   = '0;
          good_n  = '0;
          miss_n  = '0;
        end
      endcase
    end
    fwd = valid && (state_n == ST_LOCKED);
  end

  // State, counters and the single output register stage.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= ST_HUNT;
      pos          <= '0;
      good         <= '0;
      miss         <= '0;
      ts_valid     <= 1'b0;
      ts_sync      <= 1'b0;
      ts_data      <= '0;
      locked       <= 1'b0;
      lock_lost    <= 1'b0;
      sync_err_cnt <= '0;
    end else begin
      state     <= state_n;
      pos       <= pos_n;
      good      <= good_n;
      miss      <= miss_n;
      ts_valid  <= fwd;
      ts_sync   <= fwd && at_sync;
      locked    <= (state_n == ST_LOCKED);
      lock_lost <= lost_n;
      if (fwd)
        ts_data <= din_8b;
      if (err_inc && (sync_err_cnt != 16'hFFFF))
        sync_err_cnt <= sync_err_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_ts_sync_lock.sv
// Directed and randomized check of ts_sync_lock against a
// packet-level behavioural model.
module tb_ts_sync_lock;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        valid;
  logic [7:0]  din_8b;
  logic        ts_valid, ts_sync, locked, lock_lost;
  logic [7:0]  ts_data;
  logic [15:0] sync_err_cnt;

  int n_assert = 0;
  int n_fail   = 0;
  int slot     = 0;
  int seen_valid = 0;
  int seen_lost  = 0;

  // model: 0 hunting, 1 verifying, 2 locked
  int m_mode, m_pos, m_good, m_miss, m_err;
  int e_valid, e_sync, e_lost;
  int e_data;

  always #5 clk = ~clk;

  ts_sync_lock dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .valid        (valid),
    .din_8b       (din_8b),
    .ts_valid     (ts_valid),
    .ts_sync      (ts_sync),
    .ts_data      (ts_data),
    .locked       (locked),
    .lock_lost    (lock_lost),
    .sync_err_cnt (sync_err_cnt)
  );

  task automatic chk(input string tag, input int obs, input int exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model(input bit r, input bit v, input int d);
    bit hdr;
    e_valid = 0;
    e_sync  = 0;
    e_lost  = 0;
    if (!r) begin
      m_mode = 0; m_pos = 0; m_good = 0; m_miss = 0;
      m_err = 0; e_data = 0;
      return;
    end
    if (!v) return;
    hdr = (m_pos == 0);
    if (m_mode == 0) begin
      if (d == 8'h47) begin
        m_good = 1;
        m_miss = 0;
        m_mode = 1;
        m_pos  = 1;
      end
    end else if (m_mode == 1) begin
      if (hdr && d != 8'h47) begin
        m_mode = 0; m_good = 0; m_pos = 0;
      end else begin
        if (hdr) m_good = m_good + 1;
        m_pos = (m_pos + 1) % 188;
      end
    end else begin
      m_pos = (m_pos + 1) % 188;
      if (hdr && d == 8'h47) m_miss = 0;
      if (hdr && d != 8'h47) begin
        m_miss = m_miss + 1;
        if (m_err < 65535) m_err = m_err + 1;
        if (m_miss == 3) begin
          m_mode = 0; m_pos = 0; m_good = 0; e_lost = 1;
        end
      end
    end
    if (m_mode == 1 && m_good == 3) begin
      m_mode = 2;
      m_miss = 0;
    end
    if (m_mode == 2) begin
      e_valid = 1;
      e_sync  = hdr;
      e_data  = d;
    end
  endtask

  task automatic cyc(input bit r, input bit v, input logic [7:0] d);
    rst_n  = r;
    valid  = v;
    din_8b = d;
    @(posedge clk);
    #1;
    model(r, v, int'(d));
    if (ts_valid === 1'b1) seen_valid++;
    if (lock_lost === 1'b1) seen_lost++;
    chk("ts_valid", int'(ts_valid), e_valid);
    chk("ts_sync", int'(ts_sync), e_sync);
    chk("ts_data", int'(ts_data), e_data);
    chk("locked", int'(locked), (m_mode == 2) ? 1 : 0);
    chk("lock_lost", int'(lock_lost), e_lost);
    chk("sync_err_cnt", int'(sync_err_cnt), m_err);
  endtask

  task automatic emit(input logic [7:0] b, input int gap);
    if (gap == 1) begin
      if (slot % 4 == 3) begin
        cyc(1'b1, 1'b0, 8'($urandom));
        slot++;
      end
    end else if (gap == 2) begin
      while ($urandom_range(3) == 0) cyc(1'b1, 1'b0, 8'($urandom));
    end
    cyc(1'b1, 1'b1, b);
    slot++;
  endtask

  task automatic pkt(input logic [7:0] hdr, input int gap,
                     input bit clean, input int from, input int to);
    logic [7:0] b;
    for (int i = from; i < to; i++) begin
      b = 8'($urandom);
      if (clean && b == 8'h47) b = 8'h48;
      if (i == 0) b = hdr;
      emit(b, gap);
    end
  endtask

  initial begin
    rst_n = 1'b0; valid = 1'b0; din_8b = '0;
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, 8'h47);
    chk("reset_locked", int'(locked), 0);
    chk("reset_err", int'(sync_err_cnt), 0);

    for (int i = 0; i < 2; i++) pkt(8'h47, 0, 1'b1, 0, 188);
    chk("unlocked_after2", int'(locked), 0);
    pkt(8'h47, 0, 1'b1, 0, 1);
    chk("lock_on_3rd", int'(locked), 1);
    chk("sync_on_3rd", int'(ts_sync), 1);
    pkt(8'h47, 0, 1'b1, 1, 188);
    pkt(8'h47, 0, 1'b1, 0, 188);

    pkt(8'h00, 0, 1'b1, 0, 188);
    pkt(8'h47, 0, 1'b1, 0, 188);
    chk("one_bad_locked", int'(locked), 1);
    chk("one_bad_err", int'(sync_err_cnt), 1);

    seen_lost = 0;
    for (int i = 0; i < 3; i++) pkt(8'h00, 0, 1'b1, 0, 188);
    chk("lost_pulses", seen_lost, 1);
    chk("lost_locked", int'(locked), 0);
    chk("lost_err", int'(sync_err_cnt), 4);

    cyc(1'b0, 1'b0, 8'h00);
    seen_valid = 0;
    for (int i = 0; i < 512; i++) cyc(1'b1, 1'b1, 8'(i));
    chk("counter_no_valid", seen_valid, 0);

    cyc(1'b0, 1'b0, 8'h00);
    slot = 0;
    for (int i = 0; i < 4; i++) pkt(8'h47, 1, 1'b1, 0, 188);
    chk("duty_locked", int'(locked), 1);

    pkt(8'h47, 1, 1'b1, 0, 100);
    cyc(1'b0, 1'b1, 8'h47);
    chk("midrst_valid", int'(ts_valid), 0);
    chk("midrst_locked", int'(locked), 0);
    pkt(8'h47, 0, 1'b1, 101, 188);
    for (int i = 0; i < 2; i++) pkt(8'h47, 0, 1'b1, 0, 188);
    chk("relock_not_yet", int'(locked), 0);
    pkt(8'h47, 0, 1'b1, 0, 188);
    chk("relock", int'(locked), 1);

    for (int i = 0; i < 14; i++)
      pkt(($urandom_range(4) == 0) ? 8'($urandom) : 8'h47,
          2, 1'b0, 0, 188);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/ts_sync_lock.md
TS_SYNC_LOCK -- requirements
Module: ts_sync_lock

Interface
REQ-001 Parameters: DATA_WIDTH, default 8, TS byte width; PACKET_SIZE, default 188, bytes per TS packet; LOCK_COUNT, default 3, consecutive good sync bytes to lock; UNLOCK_COUNT, default 3, consecutive bad sync bytes to unlock.
REQ-002 clk  in  1  sole clock; all logic on its rising edge.
REQ-003 rst_n  in  1  synchronous, active-low reset.
REQ-004 valid  in  1  din_8b carries a byte this cycle.
REQ-005 din_8b  in  DATA_WIDTH  raw TS byte stream.
REQ-006 ts_valid  out  1  ts_data is a forwarded locked byte.
REQ-007 ts_sync  out  1  ts_data is packet position 0; only with ts_valid.
REQ-008 ts_data  out  DATA_WIDTH  forwarded byte.
REQ-009 locked  out  1  state is LOCKED.
REQ-010 lock_lost  out  1  one-cycle pulse on LOCKED->HUNT.
REQ-011 sync_err_cnt  out  16  bad sync bytes seen while LOCKED; saturates at 16'hFFFF.

Function
REQ-012 States: HUNT, VERIFY, LOCKED; per-cycle processing only when valid=1, else state and counters hold.
REQ-013 pos counter: 0..PACKET_SIZE-1, +1 per valid byte, wraps to 0; position 0 is the expected sync position.
REQ-014 HUNT: valid byte == 8'h47 -> VERIFY, pos<=1, good<=1; other bytes ignored, pos held at 0.
REQ-015 VERIFY, pos==0 (expected sync): byte==8'h47 -> good+1; if good+1==LOCK_COUNT -> LOCKED, miss<=0; byte!=8'h47 -> HUNT, good<=0, pos<=0.
REQ-016 VERIFY, pos!=0: pos advances only.
REQ-017 LOCKED, pos==0: byte==8'h47 -> miss<=0; else miss+1 and sync_err_cnt+1 (saturating); if miss+1==UNLOCK_COUNT -> HUNT, pos<=0, good<=0, lock_lost pulse.
REQ-018 A byte is forwarded iff the state after processing it is LOCKED; the byte completing lock is forwarded, the byte causing unlock is not.
REQ-019 Latency: forwarded byte appears on ts_data with ts_valid=1 exactly one clk after its valid input cycle; ts_sync=1 when that byte was at pos 0 (including corrupted sync bytes while still LOCKED).
REQ-020 ts_valid=0 and ts_sync=0 in every cycle not carrying a forwarded byte; ts_data holds its last value.
REQ-021 locked is registered, asserted the same cycle as the first forwarded byte, deasserted with lock_lost.
REQ-022 LOCK_COUNT=1 shall lock on the first 8'h47 seen in HUNT (HUNT->LOCKED directly, byte forwarded with ts_sync=1).
REQ-023 Input gaps (valid=0) of any length shall not disturb pos or state.

Reset
REQ-024 While rst_n=0 at a clk edge: state HUNT, pos/good/miss 0, ts_valid 0, ts_sync 0, ts_data 0, locked 0, lock_lost 0, sync_err_cnt 0.
REQ-025 Reset mid-packet shall discard lock; the first cycle after rst_n rises processes input in HUNT.

Structure
REQ-026 Shared package ts_pkg holds TS_SYNC_BYTE (8'h47), TS_PACKET_SIZE (188) and the state encoding; ts2asi-side blocks use the same package.
REQ-027 Single module, no sub-module; output register stage is the only pipeline stage.
REQ-028 Output ports map directly onto ts2asi inputs valid/din_8b (ts_valid/ts_data) for direct instantiation upstream of it.

Verification
REQ-029 Clean stream, 188-byte packets with 8'h47 headers, continuous valid -> locked rises one clk after the 3rd header, that header out with ts_sync=1, following 187 bytes forwarded with ts_sync=0.
REQ-030 Locked stream, one header corrupted to 8'h00 -> locked stays 1, ts_sync=1 on 8'h00, sync_err_cnt=1, next good header resets miss.
REQ-031 Locked stream, 3 consecutive corrupted headers -> lock_lost one-cycle pulse, locked=0, third corrupted byte and after not forwarded, sync_err_cnt=3.
REQ-032 Incrementing counter bytes (single 8'h47 per 256) -> never locked, ts_valid never 1.
REQ-033 Clean packets with valid duty 3-of-4 (as the ts2asi bench) -> lock after 3rd header, output byte order identical to input, 1-cycle latency per byte.
REQ-034 rst_n low for one clk at packet byte 100 while locked -> all outputs 0 next cycle, relock after 3 further headers.
